// File: rtl/regfile_bist_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : regfile_bist_if                                               |
// | Description : 2-read/1-write register file port bundle (BIST side = master) |
// | Revision    : 1.0                                                           |
// +-----------------------------------------------------------------------------+
interface regfile_bist_if #(
    parameter int AW = 5
);
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [AW-1:0] a3;
    logic [31:0]   wd;
    logic          we;
    logic [31:0]   r1;
    logic [31:0]   r2;

    modport master (output a1, a2, a3, wd, we, input r1, r2);
    modport slave  (input a1, a2, a3, wd, we, output r1, r2);
endinterface
`default_nettype wire

// File: rtl/regfile_bist.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : regfile_bist                                                  |
// | Description : Register file BIST: write SEED+addr pattern, read back both   |
// |               ports, report pass / error count / first failing address.     |
// | Revision    : 1.0                                                           |
// +-----------------------------------------------------------------------------+
module regfile_bist #(
    parameter int          AW       = 5,
    parameter int          NREG     = 32,
    parameter logic [31:0] SEED     = 32'hA5A50000,
    parameter int          ZERO_REG = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          start,
    input  wire logic          abort,
    regfile_bist_if.master     rf,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [AW:0]        err_cnt,
    output logic [AW-1:0]      fail_addr
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [AW-1:0] c_last_w = AW'(NREG - 1);
    localparam logic [AW-1:0] c_last_r = AW'(NREG - 2);

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [AW-1:0]   r_idx;
    logic [AW-1:0]   w_idx_p1;
    logic            w_f1;
    logic            w_f2;
    logic [AW+1:0]   w_err_sum;
    logic [AW:0]     w_err_next;

    // Read-back reference; the write pattern itself never substitutes zero.
    function automatic logic [31:0] f_expected(input logic [AW-1:0] addr);
        if (ZERO_REG != 0 && addr == '0)
            return 32'd0;
        return SEED + 32'(addr);
    endfunction

    assign w_idx_p1 = r_idx + AW'(1);

    // Port drive depends only on registered state and counter.
    assign rf.we = (r_state == S_WRITE);
    assign rf.a3 = (r_state == S_WRITE) ? r_idx : '0;
    assign rf.wd = (r_state == S_WRITE) ? (SEED + 32'(r_idx)) : 32'd0;
    assign rf.a1 = (r_state == S_READ) ? r_idx : '0;
    assign rf.a2 = (r_state == S_READ) ? w_idx_p1 : '0;
    assign busy  = (r_state == S_WRITE) || (r_state == S_READ);
    assign done  = (r_state == S_DONE);

    assign w_f1       = (rf.r1 != f_expected(r_idx));
    assign w_f2       = (rf.r2 != f_expected(w_idx_p1));
    assign w_err_sum  = {1'b0, err_cnt} + (AW+2)'(w_f1) + (AW+2)'(w_f2);
    assign w_err_next = w_err_sum[AW+1] ? '1 : w_err_sum[AW:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && !abort)
                    w_next = S_WRITE;
            end
            S_WRITE: begin
                if (abort)
                    w_next = S_IDLE;
                else if (r_idx == c_last_w)
                    w_next = S_READ;
            end
            S_READ: begin
                if (abort)
                    w_next = S_IDLE;
                else if (r_idx == c_last_r)
                    w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // An aborted cycle contributes nothing, leaving the partial result frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx     <= '0;
            err_cnt   <= '0;
            fail_addr <= '0;
            pass      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_idx     <= '0;
                        err_cnt   <= '0;
                        fail_addr <= '0;
                        pass      <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (!abort)
                        r_idx <= (r_idx == c_last_w) ? '0 : w_idx_p1;
                end
                S_READ: begin
                    if (!abort) begin
                        r_idx <= r_idx + AW'(2);
                        if (w_f1 || w_f2) begin
                            err_cnt <= w_err_next;
                            if (err_cnt == '0)
                                fail_addr <= w_f1 ? r_idx : w_idx_p1;
                        end
                    end
                end
                default: begin
                    pass <= (err_cnt == '0);
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_bist.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_regfile_bist                                               |
// | Description : Scoreboard bench for regfile_bist against a behavioural       |
// |               register file with injectable stuck-at-0 bits.                |
// | Revision    : 1.0                                                           |
// +-----------------------------------------------------------------------------+
module tb_regfile_bist;

    localparam int          AW     = 5;
    localparam int          NREG   = 32;
    localparam logic [31:0] c_seed = 32'hA5A50000;

    typedef struct {
        logic [AW-1:0] a3;
        logic [31:0]   wd;
    } wr_t;

    typedef struct {
        int            done_cyc;
        logic          pass;
        logic [AW:0]   errs;
        logic [AW-1:0] fa;
    } res_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          start2 = 1'b0;
    logic          busy, done, pass;
    logic [AW:0]   err_cnt;
    logic [AW-1:0] fail_addr;
    logic          busy2, done2, pass2;
    logic [AW:0]   err_cnt2;
    logic [AW-1:0] fail_addr2;

    logic [31:0] mem  [NREG];
    logic [31:0] mem2 [NREG];
    logic [31:0] sa0  [NREG];

    wr_t  wq [$];
    res_t sbq [$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic pass_pending = 1'b0;
    logic pass_exp = 1'b0;

    regfile_bist_if #(.AW(AW)) bus ();
    regfile_bist_if #(.AW(AW)) bus2 ();

    regfile_bist #(.AW(AW), .NREG(NREG), .SEED(c_seed), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .rf(bus.master),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .fail_addr(fail_addr)
    );

    regfile_bist #(.AW(AW), .NREG(NREG), .SEED(c_seed), .ZERO_REG(0)) dut_z0 (
        .clk(clk), .rst(rst), .start(start2), .abort(1'b0), .rf(bus2.master),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2), .fail_addr(fail_addr2)
    );

    always #5 clk = ~clk;

    // Behavioural register files: r0 hardwired to zero, faults applied on read.
    always @(posedge clk) begin
        if (bus.we && bus.a3 != '0)
            mem[bus.a3] <= bus.wd;
        if (bus2.we && bus2.a3 != '0)
            mem2[bus2.a3] <= bus2.wd;
    end
    assign bus.r1  = (bus.a1 == '0)  ? 32'd0 : (mem[bus.a1] & ~sa0[bus.a1]);
    assign bus.r2  = (bus.a2 == '0)  ? 32'd0 : (mem[bus.a2] & ~sa0[bus.a2]);
    assign bus2.r1 = (bus2.a1 == '0) ? 32'd0 : mem2[bus2.a1];
    assign bus2.r2 = (bus2.a2 == '0) ? 32'd0 : mem2[bus2.a2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every write and every done pulse pops its expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.we) begin
                if (wq.size() > 0) begin
                    check("wr_a3", 64'(bus.a3), 64'(wq[0].a3));
                    check("wr_wd", 64'(bus.wd), 64'(wq[0].wd));
                    void'(wq.pop_front());
                end else begin
                    check("wr_spurious", 64'(bus.we), 64'd0);
                end
            end
            if (pass_pending) begin
                check("pass", 64'(pass), 64'(pass_exp));
                pass_pending <= 1'b0;
            end
            if (done) begin
                if (sbq.size() > 0) begin
                    check("done_cyc", 64'(cyc), 64'(sbq[0].done_cyc));
                    check("err_cnt", 64'(err_cnt), 64'(sbq[0].errs));
                    check("fail_addr", 64'(fail_addr), 64'(sbq[0].fa));
                    pass_pending <= 1'b1;
                    pass_exp     <= sbq[0].pass;
                    void'(sbq.pop_front());
                end else begin
                    check("done_spurious", 64'(done), 64'd0);
                end
            end
        end
    end

    task automatic push_writes();
        for (int i = 0; i < NREG; i++)
            wq.push_back('{a3: AW'(i), wd: c_seed + 32'(i)});
    endtask

    task automatic run_test(input logic exp_pass, input int exp_errs, input int exp_fa,
                            input bit repulse);
        @(negedge clk);
        start = 1'b1;
        push_writes();
        @(posedge clk);
        #1;
        start = 1'b0;
        sbq.push_back('{done_cyc: cyc + 48, pass: exp_pass, errs: (AW+1)'(exp_errs),
                        fa: AW'(exp_fa)});
        for (int i = 0; i < 80 && sbq.size() > 0; i++) begin
            @(negedge clk);
            start = (repulse && i == 19);
        end
        start = 1'b0;
        if (sbq.size() > 0) begin
            check("done_timeout", 64'(sbq.size()), 64'd0);
            sbq.delete();
        end
        repeat (3) @(negedge clk);
        check("wq_drained", 64'(wq.size()), 64'd0);
        wq.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        for (int i = 0; i < NREG; i++) begin
            mem[i]  = 32'd0;
            mem2[i] = 32'd0;
            sa0[i]  = 32'd0;
        end
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_we", 64'(bus.we), 64'd0);
        check("rst_wd", 64'(bus.wd), 64'd0);
        check("rst_err", 64'(err_cnt), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Fault-free run, done in cycle 49.
        run_test(1'b1, 0, 0, 1'b0);

        // Reg 7 bit 0 stuck at 0.
        sa0[7] = 32'h1;
        run_test(1'b0, 1, 7, 1'b0);
        sa0[7] = 32'h0;

        // Regs 4 and 5 fail in the same read cycle; a1 address wins.
        sa0[4] = 32'h4;
        sa0[5] = 32'h1;
        run_test(1'b0, 2, 4, 1'b0);
        sa0[4] = 32'h0;
        sa0[5] = 32'h0;

        // Abort during write cycle 10.
        @(negedge clk);
        start = 1'b1;
        push_writes();
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_we", 64'(bus.we), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_pass", 64'(pass), 64'd0);
        check("abort_writes", 64'(wq.size()), 64'(NREG - 10));
        wq.delete();
        seen = 0;
        repeat (55) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        run_test(1'b1, 0, 0, 1'b0);

        // start and abort together in IDLE: abort wins.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("sa_idle_busy", 64'(busy), 64'd0);
        check("sa_idle_we", 64'(bus.we), 64'd0);

        // start re-pulsed in cycle 20 is ignored.
        run_test(1'b1, 0, 0, 1'b1);

        // Asynchronous reset mid-READ.
        @(negedge clk);
        start = 1'b1;
        push_writes();
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (39) @(negedge clk);
        check("midread_busy", 64'(busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_we", 64'(bus.we), 64'd0);
        check("rst_async_busy", 64'(busy), 64'd0);
        check("rst_async_done", 64'(done), 64'd0);
        check("rst_async_a1", 64'(bus.a1), 64'd0);
        check("rst_async_a2", 64'(bus.a2), 64'd0);
        check("rst_async_pass", 64'(pass), 64'd0);
        check("rst_async_err", 64'(err_cnt), 64'd0);
        check("rst_async_fa", 64'(fail_addr), 64'd0);
        wq.delete();
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // ZERO_REG=0 against a regfile whose r0 reads back zero.
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        seen = 0;
        for (int i = 0; i < 80 && seen == 0; i++) begin
            @(negedge clk);
            if (done2) seen = 1;
        end
        check("z0_done", 64'(seen), 64'd1);
        check("z0_err", 64'(err_cnt2), 64'd1);
        check("z0_fa", 64'(fail_addr2), 64'd0);
        @(negedge clk);
        check("z0_pass", 64'(pass2), 64'd0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
